// File: rtl/census_hamming_cost_pkg.sv
// rtl/census_hamming_cost_pkg.sv - shared constants, types and elaboration helpers for census_hamming_cost
// Contents: LATENCY, video control struct, clog2 / div_round_up / invalid_cost constant functions.
package census_hamming_cost_pkg;

   // Input sample to output, in clocks. Stage 1 (xor/mask), stage 2 (partials), stage 3 (sum).
   localparam int LATENCY = 3;

   typedef struct packed {
      logic de;
      logic h_sync;
      logic v_sync;
   } video_ctrl_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   function automatic int div_round_up(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // All-ones cost marks a disparity that has no right pixel yet on this line.
   function automatic int invalid_cost(input int cost_width);
      return (1 << cost_width) - 1;
   endfunction

endpackage

// File: rtl/census_hamming_cost_popcount_pipe.sv
// rtl/census_hamming_cost_popcount_pipe.sv - two-stage registered popcount of one xor vector
// Ports: clk, rst (sync, active high); data/valid/live from stage 1; cost is the stage-3 result.
module census_hamming_cost_popcount_pipe
   import census_hamming_cost_pkg::*;
#(
   parameter int WIDTH       = 49,
   parameter int GROUP_WIDTH = 7,
   parameter int COST_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  live,
   input  logic                  valid,
   input  logic [WIDTH-1:0]      data,
   output logic [COST_WIDTH-1:0] cost
);

   localparam int NUM_GROUPS = div_round_up(WIDTH, GROUP_WIDTH);
   localparam int PART_WIDTH = clog2(GROUP_WIDTH + 1);
   localparam int PAD_WIDTH  = NUM_GROUPS * GROUP_WIDTH;
   localparam logic [COST_WIDTH-1:0] INVALID_COST = COST_WIDTH'(invalid_cost(COST_WIDTH));

   logic [PAD_WIDTH-1:0]  data_pad;
   logic [PART_WIDTH-1:0] part_d [NUM_GROUPS];
   logic [PART_WIDTH-1:0] part_q [NUM_GROUPS];
   logic                  valid_q;
   logic                  live_q;
   logic [COST_WIDTH-1:0] sum;

   // Upper bits of the last group are zero so it can be counted like the others.
   assign data_pad = PAD_WIDTH'(data);

   always_comb begin
      part_d = '{default: '0};
      for (int g = 0; g < NUM_GROUPS; g++) begin
         for (int b = 0; b < GROUP_WIDTH; b++) begin
            part_d[g] = part_d[g] + PART_WIDTH'(data_pad[g*GROUP_WIDTH + b]);
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         sum = sum + COST_WIDTH'(part_q[g]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         part_q  <= '{default: '0};
         valid_q <= 1'b0;
         live_q  <= 1'b0;
         cost    <= '0;
      end else begin
         part_q  <= part_d;
         valid_q <= valid;
         live_q  <= live;
         // Slots still flushing from reset stay at zero rather than reporting INVALID_COST.
         if (!live_q) begin
            cost <= '0;
         end else if (valid_q) begin
            cost <= sum;
         end else begin
            cost <= INVALID_COST;
         end
      end
   end

endmodule

// File: rtl/census_hamming_cost.sv
// rtl/census_hamming_cost.sv - per-disparity Hamming cost between left census and right census history
// Ports: clk, rst (sync, active high); de/h_sync/v_sync and census_left/right inputs;
//        de/h_sync/v_sync outputs delayed by LATENCY, aligned with cost_out (d at [d*COST_WIDTH +: COST_WIDTH]).
module census_hamming_cost
   import census_hamming_cost_pkg::*;
#(
   parameter int CENSUS_WIDTH  = 49,
   parameter int MAX_DISPARITY = 16,
   parameter int COST_WIDTH    = 6,
   parameter int GROUP_WIDTH   = 7
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                de_in,
   input  logic                                h_sync_in,
   input  logic                                v_sync_in,
   input  logic [CENSUS_WIDTH-1:0]             census_left_in,
   input  logic [CENSUS_WIDTH-1:0]             census_right_in,
   output logic                                de_out,
   output logic                                h_sync_out,
   output logic                                v_sync_out,
   output logic [MAX_DISPARITY*COST_WIDTH-1:0] cost_out
);

   localparam int CNT_WIDTH = clog2(MAX_DISPARITY) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_DISPARITY);

   // hist_q[k-1] stores hist[k]; hist[0] is the live right input.
   logic [CENSUS_WIDTH-1:0]               hist_q [MAX_DISPARITY-1];
   logic [CENSUS_WIDTH-1:0]               hist   [MAX_DISPARITY];
   logic [CNT_WIDTH-1:0]                  col_cnt;
   logic [MAX_DISPARITY-1:0]              valid_d;
   logic [MAX_DISPARITY-1:0]              valid_q;
   logic [MAX_DISPARITY*CENSUS_WIDTH-1:0] xor_d;
   logic [MAX_DISPARITY*CENSUS_WIDTH-1:0] xor_q;
   logic                                  live_q;
   video_ctrl_t                           ctrl_q [LATENCY];

   always_comb begin
      hist[0] = census_right_in;
      for (int k = 1; k < MAX_DISPARITY; k++) begin
         hist[k] = hist_q[k-1];
      end
   end

   // col_cnt is the count before this pixel, so pixel n of a line validates d <= n.
   always_comb begin
      valid_d = '0;
      xor_d   = '0;
      for (int d = 0; d < MAX_DISPARITY; d++) begin
         valid_d[d] = (col_cnt >= CNT_WIDTH'(d));
         xor_d[d*CENSUS_WIDTH +: CENSUS_WIDTH] = census_left_in ^ hist[d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MAX_DISPARITY - 1; k++) begin
            hist_q[k] <= '0;
         end
         col_cnt <= '0;
      end else begin
         if (de_in) begin
            for (int k = 0; k < MAX_DISPARITY - 1; k++) begin
               hist_q[k] <= hist[k];
            end
         end
         if (!de_in) begin
            col_cnt <= '0;
         end else if (col_cnt != CNT_MAX) begin
            col_cnt <= col_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // Stage 1 plus the control delay line; live_q marks that the pipeline holds real samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         xor_q   <= '0;
         valid_q <= '0;
         live_q  <= 1'b0;
         for (int i = 0; i < LATENCY; i++) begin
            ctrl_q[i] <= '0;
         end
      end else begin
         xor_q     <= xor_d;
         valid_q   <= valid_d;
         live_q    <= 1'b1;
         ctrl_q[0] <= {de_in, h_sync_in, v_sync_in};
         for (int i = 1; i < LATENCY; i++) begin
            ctrl_q[i] <= ctrl_q[i-1];
         end
      end
   end

   census_hamming_cost_popcount_pipe #(
      .WIDTH       (CENSUS_WIDTH),
      .GROUP_WIDTH (GROUP_WIDTH),
      .COST_WIDTH  (COST_WIDTH)
   ) u_popcount [MAX_DISPARITY-1:0] (
      .clk   (clk),
      .rst   (rst),
      .live  (live_q),
      .valid (valid_q),
      .data  (xor_q),
      .cost  (cost_out)
   );

   assign de_out     = ctrl_q[LATENCY-1].de;
   assign h_sync_out = ctrl_q[LATENCY-1].h_sync;
   assign v_sync_out = ctrl_q[LATENCY-1].v_sync;

endmodule

// File: tb/tb_census_hamming_cost.sv
// tb/tb_census_hamming_cost.sv - scoreboard bench for census_hamming_cost with directed line patterns
module tb_census_hamming_cost;

   localparam int CW    = 49;
   localparam int MD    = 16;
   localparam int KW    = 6;
   localparam int COSTV = MD * KW;
   localparam int LAT   = 3;

   logic             clk;
   logic             rst;
   logic             de_in;
   logic             h_sync_in;
   logic             v_sync_in;
   logic [CW-1:0]    census_left_in;
   logic [CW-1:0]    census_right_in;
   logic             de_out;
   logic             h_sync_out;
   logic             v_sync_out;
   logic [COSTV-1:0] cost_out;

   typedef struct {
      logic             de;
      logic             hs;
      logic             vs;
      logic [COSTV-1:0] cost;
      logic [MD-1:0]    mask;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_item   = 0;

   census_hamming_cost #(
      .CENSUS_WIDTH  (CW),
      .MAX_DISPARITY (MD),
      .COST_WIDTH    (KW),
      .GROUP_WIDTH   (7)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .de_in           (de_in),
      .h_sync_in       (h_sync_in),
      .v_sync_in       (v_sync_in),
      .census_left_in  (census_left_in),
      .census_right_in (census_right_in),
      .de_out          (de_out),
      .h_sync_out      (h_sync_out),
      .v_sync_out      (v_sync_out),
      .cost_out        (cost_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t zero_exp();
      exp_t e;
      e.de   = 1'b0;
      e.hs   = 1'b0;
      e.vs   = 1'b0;
      e.cost = '0;
      e.mask = '1;
      return e;
   endfunction

   // kind 0: left=right=ones -> 0; kind 1: left ones, right zeros -> 49;
   // kind 2: right one-hot bit n, left one-hot bit n-3 (zero for n<3) -> 0 at d=3, else 2 (1 while n<3).
   function automatic logic [COSTV-1:0] line_cost(input int kind, input int n);
      logic [COSTV-1:0] c;
      logic [KW-1:0]    v;
      c = '0;
      for (int d = 0; d < MD; d++) begin
         if (d > n) v = 6'd63;
         else if (kind == 0) v = 6'd0;
         else if (kind == 1) v = 6'd49;
         else if (n < 3) v = 6'd1;
         else v = (d == 3) ? 6'd0 : 6'd2;
         c[d*KW +: KW] = v;
      end
      return c;
   endfunction

   task automatic drive(input logic r, input logic de, input logic hs, input logic vs,
                        input logic [CW-1:0] l, input logic [CW-1:0] rt,
                        input logic [COSTV-1:0] ec, input logic [MD-1:0] m);
      exp_t e;
      @(negedge clk);
      rst             = r;
      de_in           = de;
      h_sync_in       = hs;
      v_sync_in       = vs;
      census_left_in  = l;
      census_right_in = rt;
      if (r) begin
         // Reset flushes the two samples already in flight and the one taken now.
         for (int k = 1; k <= 2; k++) begin
            if (sb_q.size() >= k) sb_q[sb_q.size()-k] = zero_exp();
         end
         e = zero_exp();
      end else begin
         e.de   = de;
         e.hs   = hs;
         e.vs   = vs;
         e.cost = ec;
         e.mask = m;
      end
      sb_q.push_back(e);
   endtask

   task automatic idle(input int cnt, input logic hs, input logic vs);
      for (int i = 0; i < cnt; i++) begin
         drive(1'b0, 1'b0, hs, vs, '0, '0, '0, '0);
      end
   endtask

   task automatic line(input int kind, input int len, input int rst_at);
      int n_eff;
      logic [CW-1:0] l;
      logic [CW-1:0] rt;
      logic [CW-1:0] one;
      n_eff = 0;
      one   = 1;
      for (int p = 0; p < len; p++) begin
         if (kind == 0) begin
            l  = '1;
            rt = '1;
         end else if (kind == 1) begin
            l  = '1;
            rt = '0;
         end else begin
            rt = one << p;
            l  = (p >= 3) ? (one << (p - 3)) : '0;
         end
         if (p == rst_at) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, l, rt, '0, '0);
            n_eff = 0;
         end else begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, l, rt, line_cost(kind, n_eff), '1);
            n_eff++;
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() == LAT) begin
            e = sb_q.pop_front();
            n_checks++;
            if (de_out !== e.de) begin
               n_fail++;
               $display("FAIL de_out item %0d: got %b expected %b", n_item, de_out, e.de);
            end
            n_checks++;
            if (h_sync_out !== e.hs) begin
               n_fail++;
               $display("FAIL h_sync_out item %0d: got %b expected %b", n_item, h_sync_out, e.hs);
            end
            n_checks++;
            if (v_sync_out !== e.vs) begin
               n_fail++;
               $display("FAIL v_sync_out item %0d: got %b expected %b", n_item, v_sync_out, e.vs);
            end
            for (int d = 0; d < MD; d++) begin
               if (e.mask[d]) begin
                  n_checks++;
                  if (cost_out[d*KW +: KW] !== e.cost[d*KW +: KW]) begin
                     n_fail++;
                     $display("FAIL cost[%0d] item %0d: got %0d expected %0d",
                              d, n_item, cost_out[d*KW +: KW], e.cost[d*KW +: KW]);
                  end
               end
            end
            n_item++;
         end
      end
   end

   initial begin : stimulus
      rst             = 1'b1;
      de_in           = 1'b0;
      h_sync_in       = 1'b0;
      v_sync_in       = 1'b0;
      census_left_in  = '0;
      census_right_in = '0;

      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
      idle(1, 1'b0, 1'b0);
      idle(2, 1'b1, 1'b0);
      idle(1, 1'b0, 1'b1);
      idle(2, 1'b1, 1'b1);
      idle(1, 1'b0, 1'b0);

      line(0, 20, -1);
      idle(2, 1'b1, 1'b0);
      idle(1, 1'b0, 1'b0);
      line(1, 20, -1);
      idle(3, 1'b1, 1'b0);
      line(2, 12, -1);
      idle(2, 1'b1, 1'b1);

      line(0, 5, -1);
      idle(2, 1'b1, 1'b0);
      line(0, 5, -1);
      idle(2, 1'b0, 1'b1);

      line(0, 16, 8);
      idle(4, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
